gray_cnt_arbiter: RTL and testbench
===================================

// Module: gray_cnt_arbiter
// PURPOSE
//  Shares one free-running WIDTH-bit Gray-code sequence counter between N_REQ requesters.
//  Each requester asks for a run of L counts; a round-robin arbiter grants one run at a time.
//  An FSM sequences the run and reports completion or abort back to the owner.
//  Sits between pointer/sequence consumers and the shared Gray counting resource.
// PARAMETERS
//  N_REQ  4  number of requesters (>=2)
//  WIDTH  4  Gray counter width (>=3)
//  LEN_W  4  width of per-requester run length
// PORTS
//  clk_i       in   1            clock, all logic on rising edge
//  rst_i       in   1            synchronous reset, active-high
//  req_i       in   N_REQ        request per requester; hold high until done_o
//  len_i       in   N_REQ*LEN_W  run length, requester k at [k*LEN_W +: LEN_W]
//  gnt_o       out  N_REQ        one-hot grant, high for whole RUN/DONE of owner
//  busy_o      out  1            FSM not in IDLE
//  cnt_en_o    out  1            counter advances at end of this cycle
//  gray_cnt_o  out  WIDTH        registered Gray value of shared counter
//  carry_o     out  1            one-cycle pulse when counter wraps to 0
//  done_o      out  N_REQ        one-cycle pulse to owner at end of run
//  abort_o     out  1            qualifies done_o: run ended early
// BEHAVIOUR
//  Reset: all outputs 0; FSM=IDLE; counter bin=0; rr pointer=0 (req 0 highest first).
//  Reset mid-run: run discarded, no done_o, counter returns to 0.
//  Counter: internal binary bin, gray_cnt_o = bin ^ (bin>>1), registered together.
//   Advances by 1 only when cnt_en_o=1; wraps max->0 (Gray 10..0 -> 0), carry_o=1 the cycle after wrap edge.
//   Counter is NOT cleared between runs; each run continues the shared sequence.
//  FSM states: IDLE, RUN, DONE.
//   IDLE: if any req_i, pick first set bit at/after rr pointer (circular); latch owner k,
//     rem <= len_i[k]; gnt_o[k] <= 1. Next: RUN if len!=0, else DONE. No req -> stay.
//   RUN: cnt_en_o=1 while req_i[k]=1; rem decrements each cycle; after L cycles -> DONE.
//     If req_i[k]=0 in RUN: cnt_en_o=0 that cycle, abort latched, -> DONE.
//   DONE: done_o[k]=1, abort_o=abort latch, gnt_o[k] still 1; rr pointer <= k+1 mod N_REQ;
//     -> IDLE. Arbitration for next run happens in IDLE (1 idle cycle between runs).
//  Latency: req seen in IDLE cycle t -> gnt_o at t+1 -> L cnt_en_o cycles t+1..t+L
//     -> done_o at t+L+1 -> IDLE at t+L+2.
//  len=0: granted, no advance, done_o at t+1, abort_o=0.
//  len_i sampled only at grant; changes during run ignored. req_i of non-owners ignored until IDLE.
//  Exactly L Gray steps per unaborted run; each step changes exactly one bit of gray_cnt_o.
//  busy_o=1 in RUN and DONE. gnt_o is one-hot or zero, never multi-hot.
// TESTING
//  1 rst, req_i=0001, len0=3 -> gnt 0001 cyc1, cnt_en 3 cycles, gray 0->1->3->2, done_o=0001, abort 0.
//  2 req_i=1111 all len=1 held -> grants order 0,1,2,3,0; gray advances 1 per run.
//  3 owner 2 len=5, drop req_i[2] after 2 cnt_en -> done_o=0100, abort_o=1, gray advanced 2 only.
//  4 from gray 4'b1001 (bin 14) len=3 -> 1000, 0000 (carry_o pulse), 0001.
//  5 len=0 on req 1 -> gnt 0010 then done 0010 next cycle, gray unchanged, cnt_en never high.
//  6 assert rst_i mid-RUN -> next cycle all outputs 0, gray 0, no done_o; next grant goes to req 0.
//  Checkers: one-hot gnt, single-bit Gray change per cnt_en, cnt_en count == len for clean runs.

Source files
------------

// File: rtl/gray_cnt_arbiter_if.sv
// Bus between the requesters and the shared Gray counter arbiter.
// The requester side (master) drives req_i/len_i and receives the grant, status,
// counter value and completion pulses. The arbiter side (slave) does the reverse.
// Signal names carry the arbiter's direction suffix so they read the same at both ends.
interface gray_cnt_arbiter_if #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned WIDTH = 4,
  parameter int unsigned LEN_W = 4
);
  logic [N_REQ-1:0]       req_i;
  logic [N_REQ*LEN_W-1:0] len_i;
  logic [N_REQ-1:0]       gnt_o;
  logic                   busy_o;
  logic                   cnt_en_o;
  logic [WIDTH-1:0]       gray_cnt_o;
  logic                   carry_o;
  logic [N_REQ-1:0]       done_o;
  logic                   abort_o;

  modport master (
    output req_i, len_i,
    input  gnt_o, busy_o, cnt_en_o, gray_cnt_o, carry_o, done_o, abort_o
  );

  modport slave (
    input  req_i, len_i,
    output gnt_o, busy_o, cnt_en_o, gray_cnt_o, carry_o, done_o, abort_o
  );
endinterface

// File: rtl/gray_cnt_arbiter.sv
// Shares one free-running WIDTH-bit Gray-code counter between N_REQ requesters.
// A round-robin arbiter grants one run of L counts at a time; an IDLE/RUN/DONE FSM
// sequences the run and reports completion (or abort) to the owner.
// Ports:
//   clk_i  - clock, all logic on the rising edge
//   rst_i  - synchronous reset, active-high
//   bus    - slave side of gray_cnt_arbiter_if:
//            req_i/len_i in; gnt_o, busy_o, cnt_en_o, gray_cnt_o, carry_o, done_o, abort_o out
module gray_cnt_arbiter #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned WIDTH = 4,
  parameter int unsigned LEN_W = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  gray_cnt_arbiter_if.slave bus
);

  localparam int unsigned IdxW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [IdxW-1:0] LastIdx = IdxW'(N_REQ - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           r_state;
  logic [IdxW-1:0]  r_owner;
  logic [IdxW-1:0]  r_rr;
  logic [LEN_W-1:0] r_rem;
  logic [N_REQ-1:0] r_gnt;
  logic [N_REQ-1:0] r_done;
  logic             r_abort;
  logic [WIDTH-1:0] r_bin;
  logic [WIDTH-1:0] r_gray;
  logic             r_carry;

  logic [LEN_W-1:0] w_len [N_REQ];
  logic             w_found;
  logic [IdxW-1:0]  w_pick;
  logic [IdxW-1:0]  w_cand;
  int               w_sum;
  logic [N_REQ-1:0] w_pick_oh;
  logic             w_own_req;
  logic             w_cnt_en;
  logic [WIDTH-1:0] w_bin_nxt;

  always_comb begin
    for (int k = 0; k < int'(N_REQ); k++) begin
      w_len[k] = bus.len_i[k*LEN_W +: LEN_W];
    end
  end

  // Circular priority search starting at the round-robin pointer.
  always_comb begin
    w_found = 1'b0;
    w_pick  = r_rr;
    w_cand  = '0;
    w_sum   = 0;
    for (int i = 0; i < int'(N_REQ); i++) begin
      w_sum = int'(r_rr) + i;
      if (w_sum >= int'(N_REQ)) w_sum = w_sum - int'(N_REQ);
      w_cand = IdxW'(w_sum);
      if (!w_found && bus.req_i[w_cand]) begin
        w_found = 1'b1;
        w_pick  = w_cand;
      end
    end
  end

  assign w_pick_oh = {{(N_REQ-1){1'b0}}, 1'b1} << w_pick;
  assign w_own_req = bus.req_i[r_owner];
  // Combinational so a dropped request stops the counter in the same cycle.
  assign w_cnt_en  = (r_state == StRun) && w_own_req;
  assign w_bin_nxt = r_bin + WIDTH'(1);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state <= StIdle;
      r_owner <= '0;
      r_rr    <= '0;
      r_rem   <= '0;
      r_gnt   <= '0;
      r_done  <= '0;
      r_abort <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          r_done  <= '0;
          r_abort <= 1'b0;
          if (w_found) begin
            r_owner <= w_pick;
            r_rem   <= w_len[w_pick];
            r_gnt   <= w_pick_oh;
            if (w_len[w_pick] != '0) begin
              r_state <= StRun;
            end else begin
              r_state <= StDone;
              r_done  <= w_pick_oh;
            end
          end
        end
        StRun: begin
          if (!w_own_req) begin
            r_state <= StDone;
            r_done  <= r_gnt;
            r_abort <= 1'b1;
          end else begin
            r_rem <= r_rem - LEN_W'(1);
            if (r_rem == LEN_W'(1)) begin
              r_state <= StDone;
              r_done  <= r_gnt;
            end
          end
        end
        StDone: begin
          r_state <= StIdle;
          r_gnt   <= '0;
          r_done  <= '0;
          r_abort <= 1'b0;
          r_rr    <= (r_owner == LastIdx) ? '0 : r_owner + IdxW'(1);
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  // Binary and Gray are registered together so gray_cnt_o is glitch-free.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_bin   <= '0;
      r_gray  <= '0;
      r_carry <= 1'b0;
    end else begin
      r_carry <= w_cnt_en && (w_bin_nxt == '0);
      if (w_cnt_en) begin
        r_bin  <= w_bin_nxt;
        r_gray <= w_bin_nxt ^ (w_bin_nxt >> 1);
      end
    end
  end

  assign bus.gnt_o      = r_gnt;
  assign bus.busy_o     = (r_state != StIdle);
  assign bus.cnt_en_o   = w_cnt_en;
  assign bus.gray_cnt_o = r_gray;
  assign bus.carry_o    = r_carry;
  assign bus.done_o     = r_done;
  assign bus.abort_o    = r_abort;

endmodule

// File: tb/tb_gray_cnt_arbiter.sv
// Directed bench for gray_cnt_arbiter (N_REQ=4, WIDTH=4, LEN_W=4).
module tb_gray_cnt_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  req;
  logic [15:0] len;
  logic [3:0]  m_bin;
  int          n_checks;
  int          n_fails;

  gray_cnt_arbiter_if #(.N_REQ(4), .WIDTH(4), .LEN_W(4)) u_if ();

  assign u_if.req_i = req;
  assign u_if.len_i = len;

  gray_cnt_arbiter #(.N_REQ(4), .WIDTH(4), .LEN_W(4)) u_dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (u_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [3:0] to_gray(input logic [3:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    check_eq("gnt_onehot", 32'($onehot0(u_if.gnt_o)), 32'd1);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = '0;
    tick();
    check_eq("rst_gnt", 32'(u_if.gnt_o), 0);
    check_eq("rst_busy", 32'(u_if.busy_o), 0);
    check_eq("rst_cnt_en", 32'(u_if.cnt_en_o), 0);
    check_eq("rst_gray", 32'(u_if.gray_cnt_o), 0);
    check_eq("rst_carry", 32'(u_if.carry_o), 0);
    check_eq("rst_done", 32'(u_if.done_o), 0);
    check_eq("rst_abort", 32'(u_if.abort_o), 0);
    rst   = 1'b0;
    m_bin = '0;
  endtask

  // Called in IDLE with req/len already set; returns one cycle after DONE (back in IDLE).
  task automatic run_one(input int k, input int l, input int drop_at);
    int         n_en;
    bit         aborted;
    logic [3:0] g_prev;
    n_en    = 0;
    aborted = 1'b0;
    tick();
    check_eq("grant", 32'(u_if.gnt_o), 32'(1) << k);
    check_eq("busy_grant", 32'(u_if.busy_o), 1);
    for (int c = 0; c < l && !aborted; c++) begin
      if (c == drop_at) begin
        req[k] = 1'b0;
        #1;
        check_eq("cnt_en_on_drop", 32'(u_if.cnt_en_o), 0);
        aborted = 1'b1;
        tick();
      end else begin
        check_eq("cnt_en_run", 32'(u_if.cnt_en_o), 1);
        if (u_if.cnt_en_o) n_en++;
        g_prev = u_if.gray_cnt_o;
        tick();
        m_bin++;
        check_eq("gray_step", 32'(u_if.gray_cnt_o), 32'(to_gray(m_bin)));
        check_eq("gray_one_bit", 32'($countones(u_if.gray_cnt_o ^ g_prev)), 1);
        check_eq("carry_step", 32'(u_if.carry_o), 32'(m_bin == 4'd0));
      end
    end
    check_eq("done", 32'(u_if.done_o), 32'(1) << k);
    check_eq("abort", 32'(u_if.abort_o), 32'(aborted));
    check_eq("gnt_in_done", 32'(u_if.gnt_o), 32'(1) << k);
    check_eq("cnt_en_in_done", 32'(u_if.cnt_en_o), 0);
    check_eq("carry_in_done", 32'(u_if.carry_o), 0);
    check_eq("gray_hold", 32'(u_if.gray_cnt_o), 32'(to_gray(m_bin)));
    if (!aborted) check_eq("cnt_en_count", 32'(n_en), 32'(l));
    tick();
    check_eq("idle_busy", 32'(u_if.busy_o), 0);
    check_eq("idle_gnt", 32'(u_if.gnt_o), 0);
    check_eq("idle_done", 32'(u_if.done_o), 0);
    check_eq("idle_abort", 32'(u_if.abort_o), 0);
  endtask

  initial begin
    n_checks = 0;
    n_fails  = 0;
    rst      = 1'b1;
    req      = '0;
    len      = '0;
    m_bin    = '0;

    // Basic run: owner 0, len 3 -> gray 0,1,3,2.
    do_reset();
    req = 4'b0001;
    len = 16'h0003;
    run_one(0, 3, -1);
    check_eq("t1_gray_final", 32'(u_if.gray_cnt_o), 32'h2);
    req = '0;

    // All requesting, len 1 each: round-robin 0,1,2,3,0.
    do_reset();
    req = 4'b1111;
    len = 16'h1111;
    run_one(0, 1, -1);
    run_one(1, 1, -1);
    run_one(2, 1, -1);
    run_one(3, 1, -1);
    run_one(0, 1, -1);
    check_eq("t2_gray_final", 32'(u_if.gray_cnt_o), 32'h7);
    req = '0;

    // Owner 2 len 5, dropped after two counts (rr=1 so 2 is picked).
    req = 4'b0100;
    len = 16'h0500;
    run_one(2, 5, 2);
    check_eq("t3_gray_final", 32'(u_if.gray_cnt_o), 32'h4);
    req = '0;

    // Advance bin 7 -> 14 on requester 3, then wrap through 0 on requester 0.
    req = 4'b1000;
    len = 16'h7000;
    run_one(3, 7, -1);
    check_eq("t4_gray_pre", 32'(u_if.gray_cnt_o), 32'h9);
    req = 4'b0001;
    len = 16'h0003;
    run_one(0, 3, -1);
    check_eq("t4_gray_final", 32'(u_if.gray_cnt_o), 32'h1);
    req = '0;

    // Zero-length run on requester 1: grant and done together, no counting.
    req = 4'b0010;
    len = 16'h0000;
    run_one(1, 0, -1);
    check_eq("t5_gray_final", 32'(u_if.gray_cnt_o), 32'h1);
    req = '0;

    // Reset in the middle of a run (rr=2 picks requester 2).
    req = 4'b0100;
    len = 16'h0500;
    tick();
    check_eq("t6_grant", 32'(u_if.gnt_o), 32'h4);
    tick();
    tick();
    check_eq("t6_gray_mid", 32'(u_if.gray_cnt_o), 32'(to_gray(4'd3)));
    do_reset();
    req = 4'b1111;
    len = 16'h1111;
    tick();
    check_eq("t6_regrant", 32'(u_if.gnt_o), 32'h1);
    check_eq("t6_no_done", 32'(u_if.done_o), 0);
    req = '0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
